// File: rtl/opcode_dispatcher_pkg.sv
// Opcode transport types and dispatcher-local types/helpers.
// Opcode_p is the shared parser/FIFO format; OpcodeDispatcher_p is private to the dispatcher.
package Opcode_p;

  typedef enum logic [3:0] {
    OP_G00 = 4'd0,
    OP_G01 = 4'd1,
    OP_G02 = 4'd2,
    OP_G03 = 4'd3,
    OP_G04 = 4'd4,
    OP_M03 = 4'd5,
    OP_M05 = 4'd6,
    OP_NOP = 4'd15
  } Opcode_t;

  typedef struct packed {
    Opcode_t            op;
    logic signed [15:0] arg1;
    logic signed [15:0] arg2;
  } Opcode_st;

endpackage

package OpcodeDispatcher_p;
  import Opcode_p::*;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_TRIGGER   = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_FINISH    = 3'd4,
    S_ERROR     = 3'd5
  } DispatchState_t;

  localparam logic PEN_UP   = 1'b0;
  localparam logic PEN_DOWN = 1'b1;

  function automatic logic op_is_linear(input Opcode_t op);
    return (op == OP_G00) || (op == OP_G01);
  endfunction

  function automatic logic op_is_circular(input Opcode_t op);
    return (op == OP_G02) || (op == OP_G03);
  endfunction

  // Rapid moves travel pen-up; every drawing move needs the pen down.
  function automatic logic op_pen_down(input Opcode_t op);
    return (op == OP_G01) || (op == OP_G02) || (op == OP_G03) ? PEN_DOWN : PEN_UP;
  endfunction

endpackage

// File: rtl/opcode_dispatcher_settle.sv
// Servo settle down-counter: loads a tick count and flags the last enabled tick.
module ServoSettleTimer #(
  parameter int unsigned BITS = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_en,
  input  logic            load,
  input  logic [BITS-1:0] count,
  output logic            expired
);

  logic [BITS-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clk_en) begin
      if (load) begin
        count_q <= count;
      end else if (count_q != '0) begin
        count_q <= count_q - BITS'(1);
      end
    end
  end

  // Asserted while the final settle tick is pending, so the dwell equals the loaded count.
  assign expired = (count_q == BITS'(1));

endmodule

// File: rtl/opcode_dispatcher.sv
// Accepts one opcode at a time, settles the pen servo if needed, triggers the
// linear or circular motion processor and waits for its completion.
module opcode_dispatcher
  import Opcode_p::*;
  import OpcodeDispatcher_p::*;
#(
  parameter int unsigned SETTLE_TICKS = 25,
  parameter int unsigned SETTLE_BITS  = $clog2(SETTLE_TICKS + 1)
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clk_en,
  input  logic     opcode_valid,
  input  Opcode_st opcode_in,
  output logic     opcode_ready,
  output Opcode_st opcode_out,
  output logic     pen_down,
  output logic     linear_trigger,
  input  logic     linear_done,
  output logic     circular_trigger,
  input  logic     circular_done,
  output logic     busy,
  output logic     op_done,
  output logic     op_error
);

  // A zero-tick build still needs a one-bit counter to instantiate.
  localparam int unsigned CW = (SETTLE_BITS == 0) ? 1 : SETTLE_BITS;

  DispatchState_t state_q, state_d;
  Opcode_st       opcode_q, opcode_d;
  logic           pen_q, pen_d;
  logic           settle_load;
  logic           settle_expired;
  logic           req_pen;
  logic           supported;
  logic           sel_done;

  ServoSettleTimer #(.BITS(CW)) u_settle (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .load    (settle_load),
    .count   (CW'(SETTLE_TICKS)),
    .expired (settle_expired)
  );

  assign req_pen   = op_pen_down(opcode_in.op);
  assign supported = op_is_linear(opcode_in.op) || op_is_circular(opcode_in.op);
  assign sel_done  = op_is_linear(opcode_q.op) ? linear_done : circular_done;

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    pen_d       = pen_q;
    settle_load = 1'b0;
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (opcode_valid) begin
            if (!supported) begin
              state_d = S_ERROR;
            end else begin
              opcode_d = opcode_in;
              pen_d    = req_pen;
              if ((req_pen != pen_q) && (SETTLE_TICKS != 0)) begin
                settle_load = 1'b1;
                state_d     = S_SETTLE;
              end else begin
                state_d = S_TRIGGER;
              end
            end
          end
        end
        S_SETTLE:    if (settle_expired) state_d = S_TRIGGER;
        S_TRIGGER:   state_d = S_WAIT_DONE;
        S_WAIT_DONE: if (sel_done) state_d = S_FINISH;
        S_FINISH:    state_d = S_IDLE;
        S_ERROR:     state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      pen_q    <= PEN_UP;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      pen_q    <= pen_d;
    end
  end

  assign opcode_ready     = (state_q == S_IDLE) && !reset;
  assign opcode_out       = opcode_q;
  assign pen_down         = pen_q;
  assign linear_trigger   = (state_q == S_TRIGGER) && op_is_linear(opcode_q.op);
  assign circular_trigger = (state_q == S_TRIGGER) && op_is_circular(opcode_q.op);
  assign busy             = (state_q != S_IDLE);
  assign op_done          = (state_q == S_FINISH);
  assign op_error         = (state_q == S_ERROR);

endmodule

// File: tb/tb_opcode_dispatcher.sv
// Self-checking bench for opcode_dispatcher: directed scenarios plus random
// opcode streams checked against a transaction-level timeline model.
module tb_opcode_dispatcher;
  import Opcode_p::*;

  localparam int unsigned TICKS = 4;

  logic     clk = 1'b0;
  logic     reset, clk_en, opcode_valid, linear_done, circular_done;
  Opcode_st opcode_in, opcode_out;
  logic     opcode_ready, pen_down, linear_trigger, circular_trigger;
  logic     busy, op_done, op_error;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned en_period = 1;
  logic        model_pen;
  Opcode_st    model_out;

  opcode_dispatcher #(.SETTLE_TICKS(TICKS)) dut (
    .clk              (clk),
    .reset            (reset),
    .clk_en           (clk_en),
    .opcode_valid     (opcode_valid),
    .opcode_in        (opcode_in),
    .opcode_ready     (opcode_ready),
    .opcode_out       (opcode_out),
    .pen_down         (pen_down),
    .linear_trigger   (linear_trigger),
    .linear_done      (linear_done),
    .circular_trigger (circular_trigger),
    .circular_done    (circular_done),
    .busy             (busy),
    .op_done          (op_done),
    .op_error         (op_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic edge_(input logic en);
    clk_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic en_edge();
    for (int i = 1; i < int'(en_period); i++) edge_(1'b0);
    edge_(1'b1);
  endtask

  function automatic Opcode_st mk(input logic [3:0] op, input logic [15:0] a1, input logic [15:0] a2);
    Opcode_st o;
    o.op   = Opcode_t'(op);
    o.arg1 = a1;
    o.arg2 = a2;
    return o;
  endfunction

  function automatic Opcode_st rand_op();
    return mk(4'($urandom), 16'($urandom), 16'($urandom));
  endfunction

  // Full transaction: accept, optional settle, trigger, wait dly enabled cycles, done.
  task automatic run_op(input Opcode_st o, input int unsigned dly);
    logic [3:0] v;
    logic       sup, lin, req, settle;
    int unsigned span;
    v      = o.op;
    sup    = (v <= 4'd3);
    lin    = (v <= 4'd1);
    req    = (v != 4'd0);
    settle = sup && (req != model_pen);
    span   = TICKS * en_period;

    chk("ready_pre", opcode_ready, 1);
    opcode_in    = o;
    opcode_valid = 1'b1;
    for (int i = 1; i < int'(en_period); i++) begin
      edge_(1'b0);
      chk("no_accept_without_en", busy, 0);
    end
    edge_(1'b1);
    opcode_valid = 1'b0;
    opcode_in    = rand_op();
    if (sup) begin
      model_pen = req;
      model_out = o;
    end
    chk("pen_at_accept", pen_down, model_pen);
    chk("opcode_out_accept", opcode_out, model_out);
    chk("busy_accept", busy, 1);
    chk("ready_accept", opcode_ready, 0);
    chk("op_error_accept", op_error, !sup);

    if (!sup) begin
      chk("error_no_trigger", {linear_trigger, circular_trigger}, 0);
      en_edge();
      chk("error_pulse_end", op_error, 0);
      chk("ready_after_error", opcode_ready, 1);
      return;
    end

    if (settle) begin
      for (int unsigned i = 1; i <= span; i++) begin
        linear_done   = 1'($urandom);
        circular_done = 1'($urandom);
        edge_((i % en_period) == 0);
        chk("settle_trigger", linear_trigger | circular_trigger, i == span);
      end
    end

    chk("linear_trigger", linear_trigger, lin);
    chk("circular_trigger", circular_trigger, !lin);
    for (int i = 1; i < int'(en_period); i++) begin
      edge_(1'b0);
      chk("trigger_hold", linear_trigger | circular_trigger, 1);
    end
    linear_done   = 1'($urandom);
    circular_done = 1'($urandom);
    edge_(1'b1);
    chk("trigger_end", {linear_trigger, circular_trigger}, 0);
    chk("no_early_done", op_done, 0);

    for (int unsigned d = 0; d < dly; d++) begin
      if (lin) begin linear_done = 1'b0; circular_done = 1'($urandom); end
      else     begin circular_done = 1'b0; linear_done = 1'($urandom); end
      en_edge();
      chk("wait_no_done", op_done, 0);
      chk("wait_busy", busy, 1);
    end
    if (lin) begin linear_done = 1'b1; circular_done = 1'($urandom); end
    else     begin circular_done = 1'b1; linear_done = 1'($urandom); end
    en_edge();
    linear_done   = 1'b0;
    circular_done = 1'b0;
    chk("op_done", op_done, 1);
    chk("opcode_out_hold", opcode_out, model_out);
    chk("pen_hold", pen_down, model_pen);
    en_edge();
    chk("op_done_end", op_done, 0);
    chk("ready_post", opcode_ready, 1);
  endtask

  initial begin
    logic       found;
    logic [3:0] v;

    reset         = 1'b1;
    clk_en        = 1'b1;
    opcode_valid  = 1'b0;
    linear_done   = 1'b0;
    circular_done = 1'b0;
    opcode_in     = '0;
    model_pen     = 1'b0;
    model_out     = '0;

    edge_(1'b1);
    edge_(1'b1);
    chk("rst_ready", opcode_ready, 0);
    chk("rst_outs", {busy, op_done, op_error, linear_trigger, circular_trigger, pen_down}, 0);
    chk("rst_opcode_out", opcode_out, 0);
    reset = 1'b0;
    edge_(1'b1);
    chk("post_rst_ready", opcode_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Directed scenarios at full enable rate
    run_op(mk(4'd1, 16'd10, 16'd5), 7);
    run_op(mk(4'd1, 16'd20, 16'd3), 0);
    run_op(mk(4'd2, 16'd7, 16'hFFF0), 3);
    run_op(mk(4'd9, 16'd1, 16'd1), 0);
    run_op(mk(4'd0, 16'd100, 16'd200), 2);
    run_op(mk(4'd3, 16'd5, 16'd5), 1);

    // Sparse enable: one enabled cycle in four
    en_period = 4;
    run_op(mk(4'd0, 16'd1, 16'd2), 1);
    run_op(mk(4'd1, 16'd3, 16'd4), 2);
    run_op(mk(4'd5, 16'd0, 16'd0), 0);
    run_op(mk(4'd2, 16'd6, 16'd7), 0);
    en_period = 1;

    for (int n = 0; n < 40; n++) begin
      v = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      run_op(mk(v, 16'($urandom), 16'($urandom)), $urandom_range(0, 6));
    end

    // Reset while waiting for a linear done
    opcode_in    = mk(4'd1, 16'd42, 16'd43);
    opcode_valid = 1'b1;
    edge_(1'b1);
    opcode_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (linear_trigger) found = 1'b1;
      else edge_(1'b1);
    end
    chk("reach_trigger", found, 1);
    edge_(1'b1);
    chk("in_wait_busy", busy, 1);
    reset       = 1'b1;
    linear_done = 1'b1;
    edge_(1'b1);
    chk("midrst_outs", {busy, op_done, op_error, linear_trigger, circular_trigger, pen_down}, 0);
    chk("midrst_opcode_out", opcode_out, 0);
    chk("midrst_ready", opcode_ready, 0);
    reset = 1'b0;
    edge_(1'b1);
    chk("after_rst_ready", opcode_ready, 1);
    chk("after_rst_no_done", {op_done, busy}, 0);
    linear_done = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/opcode_dispatcher.md
# opcode_dispatcher

Sequences decoded opcodes into the motion processors. It accepts one `Opcode_p::Opcode_st` at a time over a valid/ready handshake and holds it in a register that feeds the processors. G00/G01 are routed to the linear processor and G02/G03 to the circular processor. Before a trigger, it inserts a servo settle delay whenever the pen position must change, then waits for the processor's done and reports completion upstream.

## Interface
- `SETTLE_TICKS`, default 25: clk_en ticks to wait after a pen up/down change; 0 disables settling.
- `SETTLE_BITS`, default `$clog2(SETTLE_TICKS+1)`: width of the settle counter.
- `clk` in, 1: system clock; one clock.
- `reset` in, 1: synchronous, active-high reset.
- `clk_en` in, 1: module enable; all state, counter and register updates are qualified by it.
- `opcode_valid` in, 1: upstream holds a valid opcode.
- `opcode_in` in, `Opcode_st`: opcode from parser/FIFO.
- `opcode_ready` out, 1: dispatcher can accept; equals (state==IDLE && !reset).
- `opcode_out` out, `Opcode_st`: latched opcode driving both processors.
- `pen_down` out, 1: current commanded pen state (1 = down).
- `linear_trigger` out, 1: trigger to the linear processor.
- `linear_done` in, 1: linear processor finished.
- `circular_trigger` out, 1: trigger to the circular processor.
- `circular_done` in, 1: circular processor finished.
- `busy` out, 1: state != IDLE.
- `op_done` out, 1: one-state pulse when an opcode completes.
- `op_error` out, 1: one-state pulse when an unsupported op is dropped.

## Operation
- States: IDLE, SETTLE, TRIGGER, WAIT_DONE, FINISH, ERROR.
- IDLE: accept occurs when `opcode_valid && opcode_ready && clk_en`.
  - On accept, latch `opcode_out <= opcode_in` and compute the required pen state: G01/G02/G03 = down, G00 = up.
  - Any other op goes to ERROR; `opcode_out` and `pen_down` are unchanged.
  - If the required pen state differs from `pen_down` and SETTLE_TICKS>0, update `pen_down`, load counter = SETTLE_TICKS and go to SETTLE.
  - Otherwise update `pen_down` (no change) and go to TRIGGER.
- SETTLE: counter decrements on each clk_en cycle. At counter==1 on a clk_en cycle, go to TRIGGER. Total SETTLE dwell is exactly SETTLE_TICKS enabled cycles.
- TRIGGER:
  - `linear_trigger` = (state==TRIGGER && op in {G00,G01}).
  - `circular_trigger` = (state==TRIGGER && op in {G02,G03}).
  - Go to WAIT_DONE on the next clk_en cycle.
- WAIT_DONE: sample only the selected processor's done on clk_en cycles; the other done input is ignored. On done=1 go to FINISH. There is no timeout.
- FINISH: `op_done`=1; go to IDLE on the next clk_en cycle.
- ERROR: `op_error`=1; go to IDLE on the next clk_en cycle.
- Done asserted while not in WAIT_DONE is ignored; it is not remembered.
- `opcode_valid` while not in IDLE is ignored. `opcode_in` may change freely; `opcode_out` is stable from accept until the next accept.
- Reset, including mid-operation:
  - state=IDLE, counter=0.
  - `opcode_out`=all zeros, `pen_down`=0.
  - Triggers, `busy`, `op_done`, `op_error` all 0.
  - A processor done arriving after reset is ignored. The processors share the same reset.

## Timing
- All figures below assume clk_en=1 every cycle; with sparse clk_en, every state dwell stretches to the next enabled cycle.
- Outputs are state-decoded and therefore glitch-free. A trigger or pulse held through clk_en=0 cycles lasts until the next enabled edge.
- Accept at edge E0:
  - No pen change: trigger high during cycle E0..E1.
  - Pen change: trigger high from E0+SETTLE_TICKS to E0+SETTLE_TICKS+1.
- Done sampled high at edge Ed: `op_done` high Ed..Ed+1; `opcode_ready` high again after Ed+1.
- Minimum throughput: 4 cycles per opcode when done returns on the first WAIT_DONE edge.
- Error path: `op_error` high E0..E1; `opcode_ready` high after E1.
- `pen_down` changes at the accept edge, so the servo starts moving during SETTLE.

## Structure
- Package `OpcodeDispatcher_p` holds:
  - `DispatchState_t` enum (6 states).
  - `PEN_UP`/`PEN_DOWN` constants.
  - Functions `op_is_linear`, `op_is_circular`, `op_pen_down` over `Opcode_p::Opcode_t`.
- Sub-module `ServoSettleTimer` (load, clk_en, count, expired), instantiated once; the FSM stays in `opcode_dispatcher`.

## Test plan
- Reset, SETTLE_TICKS=4; send G01 (arg1=10, arg2=5); linear done 7 cycles after trigger:
  - `pen_down` rises at accept, 4-cycle SETTLE, then a one-cycle `linear_trigger`.
  - `op_done` one cycle after done; `opcode_out.arg1`=10 throughout.
- Back-to-back G01, G01: second has no SETTLE; `linear_trigger` in the cycle after accept.
- G02 with pen already down: only `circular_trigger` pulses; `linear_trigger` stays 0; a stray `linear_done`=1 in WAIT_DONE does not complete the op.
- Unsupported op: `op_error` for one cycle, no trigger, `pen_down` unchanged, ready 2 cycles after accept.
- clk_en high 1-in-4, SETTLE_TICKS=4: SETTLE lasts 16 clocks; trigger stays high 4 clocks; accept requires clk_en=1.
- `reset` during WAIT_DONE, then `linear_done`=1: all outputs at reset values next cycle, `opcode_ready`=1 after reset drops, no `op_done`.
